// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit (pc_ctrl, pc_ras).
// The optional return-address stack is built only when PC_RAS_EN is defined.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_HOLD,
    NPC_RET,
    NPC_JMP,
    NPC_BR,
    NPC_SEQ
  } npc_sel_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  // Pointer width for a RAS of the given depth; never narrower than one bit.
  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty leaves state untouched; ovf/unf are registered one-cycle pulses.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RAS_DEPTH,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned PTR_W = ras_ptr_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] tptr;
  logic [PTR_W:0]   count;

  // Pointer wrap relies on DEPTH being a power of two.
  assign tptr  = wptr - PTR_W'(1);
  assign top   = mem[tptr];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= push && full;
      unf <= pop && empty;
      if (push) begin
        wptr <= wptr + PTR_W'(1);
        if (!full) count <= count + (PTR_W+1)'(1);
      end else if (pop && !empty) begin
        wptr  <= tptr;
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit: registered fetch address with prioritised next-PC select.
// Define PC_RAS_EN to build the return-address stack used by ret/jal.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc,
  input  logic              jump,
  input  logic              jal,
  input  logic              ret,
  input  logic              pcsrc,
  input  logic [25:0]       instr,
  input  logic [ADDR_W-1:0] rs_data,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              ras_ovf,
  output logic              ras_unf
);

  npc_sel_t          sel;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] ret_target;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign br_target = pc_plus4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

  if (ADDR_W > 28) begin : g_jt
    assign jmp_target = {pc_plus4[ADDR_W-1:28], instr, 2'b00};
  end else begin : g_jt28
    assign jmp_target = {instr, 2'b00};
  end

`ifdef PC_RAS_EN
  logic              ras_empty;
  logic              ras_full;
  logic [ADDR_W-1:0] ras_top;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (sel == NPC_JMP && jal),
    .pop   (sel == NPC_RET),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  assign ret_target = ras_empty ? rs_data : ras_top;
`else
  assign ret_target = rs_data;
  assign ras_ovf    = 1'b0;
  assign ras_unf    = 1'b0;
`endif

  always_comb begin
    sel = NPC_SEQ;
    npc = pc_plus4;
    if      (exc)          sel = NPC_EXC;
    else if (stall)        sel = NPC_HOLD;
    else if (ret)          sel = NPC_RET;
    else if (jump || jal)  sel = NPC_JMP;
    else if (pcsrc)        sel = NPC_BR;
    case (sel)
      NPC_EXC:  npc = ADDR_W'(EXC_VEC);
      NPC_HOLD: npc = pc;
      NPC_RET:  npc = ret_target;
      NPC_JMP:  npc = jmp_target;
      NPC_BR:   npc = br_target;
      default:  npc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= ADDR_W'(RESET_VEC);
      epc <= '0;
    end else begin
      pc <= npc;
      if (sel == NPC_EXC) epc <= pc;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed program-flow scenarios plus random
// stimulus, compared every cycle against a queue-based reference model.
module tb_pc_ctrl;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, exc = 1'b0, jump = 1'b0, jal = 1'b0, ret = 1'b0, pcsrc = 1'b0;
  logic [25:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc, pc_plus4, epc;
  logic        ras_ovf, ras_unf;

  int total = 0;
  int bad = 0;

  pc_ctrl #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0080),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .exc      (exc),
    .jump     (jump),
    .jal      (jal),
    .ret      (ret),
    .pcsrc    (pcsrc),
    .instr    (instr),
    .rs_data  (rs_data),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .epc      (epc),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC plus a bounded LIFO of return addresses.
  logic [31:0] m_pc, m_epc;
  logic        m_ovf, m_unf;
  logic [31:0] m_ras[$];

  always @(posedge clk or negedge reset) begin
    logic [31:0] p4;
    if (!reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else begin
      p4 = m_pc + 32'd4;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (exc) begin
        m_epc = m_pc;
        m_pc  = 32'h80;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (ret) begin
        if (RAS_ON && m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc  = rs_data;
          m_unf = RAS_ON;
        end
      end else if (jump || jal) begin
        if (jal && RAS_ON) begin
          m_ras.push_back(p4);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end
        m_pc = {p4[31:28], instr, 2'b00};
      end else if (pcsrc) begin
        m_pc = p4 + ({{16{instr[15]}}, instr[15:0]} * 32'd4);
      end else begin
        m_pc = p4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("epc", epc, m_epc);
    chk("ras_ovf", {31'b0, ras_ovf}, {31'b0, m_ovf});
    chk("ras_unf", {31'b0, ras_unf}, {31'b0, m_unf});
  end

  task automatic cyc(input logic s, input logic e, input logic j, input logic jl,
                     input logic r, input logic b, input logic [25:0] in,
                     input logic [31:0] rs);
    stall = s; exc = e; jump = j; jal = jl; ret = r; pcsrc = b; instr = in; rs_data = rs;
    @(posedge clk);
    #1;
    stall = 0; exc = 0; jump = 0; jal = 0; ret = 0; pcsrc = 0; instr = '0; rs_data = '0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] rets [5];

    // Reset sequencing.
    #2 reset = 1'b0;
    #1 chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    chk("pc_after_rel", pc, 32'h0);
    idle(); chk("seq_4", pc, 32'h4);
    idle(); chk("seq_8", pc, 32'h8);

    // Branches forward and backward.
    cyc(0, 0, 0, 0, 0, 1, 26'h0010, 32'h0); chk("br_fwd", pc, 32'h4C);
    cyc(0, 0, 0, 0, 0, 1, 26'hFFFE, 32'h0); chk("br_back", pc, 32'h48);

    // jal / ret pair.
    cyc(0, 0, 1, 0, 0, 0, 26'h4, 32'h0);  chk("jump_10", pc, 32'h10);
    cyc(0, 0, 0, 1, 0, 0, 26'h40, 32'h0); chk("jal_100", pc, 32'h100);
    cyc(0, 0, 0, 0, 1, 0, 26'h0, 32'hDEAD0);
    chk("ret_pc", pc, RAS_ON ? 32'h14 : 32'hDEAD0);
    chk("ret_unf", {31'b0, ras_unf}, 32'h0);

    // Five calls into a four-deep stack, then five returns.
    rets[0] = pc + 32'd4;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 26'h100 + 26'(i) * 26'h40, 32'h0);
      if (i < 4) rets[i+1] = pc + 32'd4;
      chk("ovf_pulse", {31'b0, ras_ovf}, {31'b0, RAS_ON && i == 4});
    end
    chk("last_call_pc", pc, 32'h800);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 26'h0, 32'h300);
      chk("ret_lifo", pc, (RAS_ON && i < 4) ? rets[4-i] : 32'h300);
      chk("unf_pulse", {31'b0, ras_unf}, {31'b0, RAS_ON && i == 4});
    end

    // Stall freezes PC and suppresses a jal push; exc overrides stall.
    cyc(0, 0, 1, 0, 0, 0, 26'h9, 32'h0); chk("jump_24", pc, 32'h24);
    cyc(1, 0, 0, 0, 0, 0, 26'h0, 32'h0);  chk("stall1", pc, 32'h24);
    cyc(1, 0, 0, 1, 0, 0, 26'h40, 32'h0); chk("stall_jal", pc, 32'h24);
    cyc(1, 0, 0, 0, 0, 1, 26'h10, 32'h0); chk("stall3", pc, 32'h24);
    cyc(1, 1, 0, 0, 0, 0, 26'h0, 32'h0);  chk("exc_pc", pc, 32'h80);
    chk("exc_epc", epc, 32'h24);
    cyc(0, 0, 0, 0, 1, 0, 26'h0, 32'h200); chk("ret_empty", pc, 32'h200);
    chk("ret_empty_unf", {31'b0, ras_unf}, {31'b0, RAS_ON});

    // Reset arriving with stall and exc pending.
    stall = 1; exc = 1;
    #2 reset = 1'b0;
    #1 chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_epc", epc, 32'h0);
    @(posedge clk); #1 reset = 1'b1; stall = 0; exc = 0;
    chk("rst_win_pc", pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
          26'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
